ahb_cmd_master: RTL and testbench
=================================

Name: ahb_cmd_master

Overview:
- Hardware AHB-Lite bus master, directly upstream of the display slave and other memory-mapped slaves on the same bus.
- Accepts byte/half/word read and write commands on a valid/ready interface and buffers them in a small FIFO.
- Issues them as pipelined NONSEQ transfers that honour HREADY wait states.
- Returns one right-justified response per command, so the accelerometer datapath can drive the display without the CPU.

Parameters:
- CMD_DEPTH, 4, command FIFO depth in entries; power of 2, at least 2.
- RSP_DEPTH, 2, response buffer depth in entries; at least 1.

Ports:
- HCLK  in  1  bus clock; all state on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full; a command is accepted when cmd_valid and cmd_ready are both high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_size  in  3  HSIZE encoding: 000 byte, 001 half, 010 word.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  write data, right-justified.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
- rsp_rdata  out  32  read data, right-justified and zero-extended; 0 for writes.
- rsp_err  out  1  command failed.
- HADDR  out  32  address-phase address.
- HTRANS  out  2  IDLE=00 or NONSEQ=10 only.
- HSIZE  out  3  transfer size.
- HWRITE  out  1  transfer direction.
- HWDATA  out  32  lane-aligned write data.
- HRDATA  in  32  read data from the slave.
- HREADY  in  1  bus ready.

Behaviour:
- Reset values: HTRANS=IDLE, HADDR=0, HSIZE=0, HWRITE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cmd_ready=0.
- After reset deasserts, cmd_ready=1 from the next cycle.
- Reset mid-operation: FIFOs flushed, in-flight transfer abandoned, no response produced for it.
- Valid combinations: byte with any addr[1:0]; half with addr[1:0]=00 or 10; word with addr[1:0]=00.
- Invalid combination: no bus transfer. Produces a response with rsp_err=1 and rsp_rdata=0, in command order.
- Issue rule: the head command moves to the address phase on a rising edge only if all of the following hold:
  - HREADY=1;
  - the FIFO is non-empty;
  - outstanding transfers plus buffered responses < RSP_DEPTH.
- When a command issues, HTRANS=NONSEQ and HADDR/HSIZE/HWRITE are driven for one cycle. If nothing issues, HTRANS=IDLE and the other address signals hold their last value.
- While HREADY=0, all address-phase outputs hold stable.
- Pipelining: the address phase of transfer N+1 overlaps the data phase of transfer N. Back-to-back zero-wait transfers sustain one per cycle.
- Minimum latency with zero-wait slave and rsp_ready=1: command accepted at edge 0, address phase at edge 1, data phase completes at edge 2, rsp_valid visible after edge 2.
- HWDATA: driven on the edge that starts the data phase; held while HREADY=0.
  - Byte: data[7:0] << 8*addr[1:0].
  - Half: data[15:0] << 16*addr[1].
  - Word: unshifted.
- Read capture: on the edge where HREADY=1 ends the data phase, HRDATA is shifted right by the same lane offset and masked to the size.
- Responses are strictly in command order.
- Simultaneous accept and issue on an empty FIFO is allowed; it costs one cycle of FIFO latency and there is no bypass.
- FIFO full: cmd_ready=0. Response buffer full: issue stalls; bus goes IDLE after the current data phase.

Optional Feature:
- AHB_CMD_MASTER_HRESP_EN: adds input port HRESP (1 bit).
  - Two-cycle ERROR response, as the slave signals it: first cycle HRESP=1 with HREADY=0, second cycle HRESP=1 with HREADY=1.
  - The master drives HTRANS=IDLE in the second cycle, cancelling any pipelined next transfer. The cancelled command stays at the FIFO head and re-issues later.
  - The errored command responds with rsp_err=1.
- Without the macro: no HRESP port; rsp_err is set only for invalid size/alignment.

Decomposition:
- Shared package ahb_pkg: HTRANS constants IDLE/NONSEQ; HSIZE constants BYTE/HALF/WORD; the size/alignment-valid function; the lane-shift function.
- One sub-module, sync_fifo, parameterised on width and depth. It is instantiated for commands (68 bits) and for responses (33 bits).

Test Plan:
- Write byte 0x82 to 0x5300_0001 → one NONSEQ cycle with HSIZE=000 and HADDR=0x5300_0001; next cycle HWDATA=0x0000_8200; response with rsp_err=0.
- Four writes queued, zero-wait slave → four consecutive NONSEQ cycles with no IDLE gap; four responses in order.
- Word read from 0x5300_0000 with the slave inserting 2 wait states and then returning 0x0C11_8201 → address signals stable during the waits; rsp_rdata=0x0C11_8201.
- Byte read from 0x5300_0003 with HRDATA=0x3649_AF13 → rsp_rdata=0x0000_0036.
- Half-word command to 0x5300_0001 → no NONSEQ on the bus; rsp_err=1, rsp_rdata=0.
- rsp_ready held 0 with 6 commands queued → at most RSP_DEPTH transfers issue, then HTRANS=IDLE.
- Then HRESET pulse mid-transfer → all outputs return to reset values and rsp_valid=0.
- With the macro: ERROR response on a write while a read is pipelined → HTRANS=IDLE in the second error cycle; the write responds with rsp_err=1; the read re-issues and completes.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, command/response records and lane helpers
// used by the command master and its FIFOs.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef struct packed {
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  function automatic logic size_ok(input logic [2:0] size, input logic [1:0] off);
    case (size)
      HSIZE_BYTE: size_ok = 1'b1;
      HSIZE_HALF: size_ok = ~off[0];
      HSIZE_WORD: size_ok = (off == 2'b00);
      default:    size_ok = 1'b0;
    endcase
  endfunction

  // Right-justified data onto its byte lanes.
  function automatic logic [31:0] lane_shift(input logic [31:0] data, input logic [2:0] size,
                                             input logic [1:0] off);
    case (size)
      HSIZE_BYTE: lane_shift = {24'd0, data[7:0]} << {off, 3'b000};
      HSIZE_HALF: lane_shift = {16'd0, data[15:0]} << {off[1], 4'b0000};
      default:    lane_shift = data;
    endcase
  endfunction

  // Byte lanes back to right-justified, zero-extended data.
  function automatic logic [31:0] lane_extract(input logic [31:0] data, input logic [2:0] size,
                                               input logic [1:0] off);
    case (size)
      HSIZE_BYTE: lane_extract = (data >> {off, 3'b000}) & 32'h0000_00FF;
      HSIZE_HALF: lane_extract = (data >> {off[1], 4'b0000}) & 32'h0000_FFFF;
      default:    lane_extract = data;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with asynchronous read of the head entry.
// Callers never push when full nor pop when empty; count tells them which.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    ptr_next = (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/ahb_cmd_master.sv
// AHB-Lite master turning queued byte/half/word commands into pipelined NONSEQ
// transfers with in-order responses. Define AHB_CMD_MASTER_HRESP_EN to add HRESP.
module ahb_cmd_master
  import ahb_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
`ifdef AHB_CMD_MASTER_HRESP_EN
  input  logic        HRESP,
`endif
  input  logic        HREADY
);

  localparam int CCW = $clog2(CMD_DEPTH + 1);
  localparam int RCW = $clog2(RSP_DEPTH + 1);

  cmd_t           cmd_in, head;
  rsp_t           rsp_in, rsp_head;
  logic [CCW-1:0] cmd_cnt;
  logic [RCW-1:0] rsp_cnt;
  logic           rdy_en;
  logic           cmd_push, cmd_pop, head_vld, head_ok;
  logic           rsp_push, rsp_pop, room, can_issue, issue, err_pop, dp_done;
  logic           dp_err, err_block;
  logic [31:0]    rsp_occ;

  logic [31:0]    haddr_p0;
  logic [2:0]     hsize_p0;
  logic           hwrite_p0;
  logic           vld_p1;
  logic           write_p1;
  logic [2:0]     size_p1;
  logic [1:0]     off_p1;
  logic [31:0]    hwdata_p1;

  assign cmd_in    = '{write: cmd_write, size: cmd_size, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_ready = rdy_en & (cmd_cnt != CCW'(CMD_DEPTH));
  assign cmd_push  = cmd_valid & cmd_ready;
  assign head_vld  = (cmd_cnt != '0);
  assign head_ok   = size_ok(head.size, head.addr[1:0]);

  sync_fifo #(.DATA_W($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(HCLK), .rst(HRESET), .push(cmd_push), .wdata(cmd_in),
    .pop(cmd_pop), .rdata(head), .count(cmd_cnt)
  );

`ifdef AHB_CMD_MASTER_HRESP_EN
  logic err2_q;

  // Second ERROR cycle: bus forced IDLE so the pipelined head is cancelled.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) err2_q <= 1'b0;
    else        err2_q <= vld_p1 & HRESP & ~HREADY;
  end

  assign err_block = err2_q;
  assign dp_err    = HRESP;
`else
  assign err_block = 1'b0;
  assign dp_err    = 1'b0;
`endif

  // A response slot is owed to every transfer in its data phase; a response
  // leaving this cycle frees its slot in time for back-to-back issue.
  assign rsp_occ   = 32'(rsp_cnt) + 32'(vld_p1) - 32'(rsp_pop);
  assign room      = rsp_occ < 32'(RSP_DEPTH);
  assign can_issue = head_vld & head_ok & room & ~err_block;
  assign issue     = can_issue & HREADY;
  assign err_pop   = head_vld & ~head_ok & ~vld_p1 & room;
  assign cmd_pop   = issue | err_pop;
  assign dp_done   = vld_p1 & HREADY;

  // ---- address phase (p0): driven straight from the FIFO head ----
  assign HTRANS = can_issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR  = can_issue ? head.addr  : haddr_p0;
  assign HSIZE  = can_issue ? head.size  : hsize_p0;
  assign HWRITE = can_issue ? head.write : hwrite_p0;
  assign HWDATA = hwdata_p1;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rdy_en    <= 1'b0;
      vld_p1    <= 1'b0;
      haddr_p0  <= '0;
      hsize_p0  <= '0;
      hwrite_p0 <= 1'b0;
      hwdata_p1 <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (issue) begin
        vld_p1    <= 1'b1;
        haddr_p0  <= head.addr;
        hsize_p0  <= head.size;
        hwrite_p0 <= head.write;
        if (head.write) hwdata_p1 <= lane_shift(head.wdata, head.size, head.addr[1:0]);
      end else if (dp_done) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  // ---- data phase (p1): lane information for read capture ----
  always_ff @(posedge HCLK) begin
    if (issue) begin
      write_p1 <= head.write;
      size_p1  <= head.size;
      off_p1   <= head.addr[1:0];
    end
  end

  always_comb begin
    rsp_in = '{err: 1'b1, rdata: 32'd0};
    if (!err_pop) begin
      rsp_in.err   = dp_err;
      rsp_in.rdata = (write_p1 || dp_err) ? 32'd0 : lane_extract(HRDATA, size_p1, off_p1);
    end
  end

  assign rsp_push = dp_done | err_pop;
  assign rsp_pop  = rsp_valid & rsp_ready;

  sync_fifo #(.DATA_W($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk(HCLK), .rst(HRESET), .push(rsp_push), .wdata(rsp_in),
    .pop(rsp_pop), .rdata(rsp_head), .count(rsp_cnt)
  );

  assign rsp_valid = (rsp_cnt != '0);
  assign rsp_rdata = rsp_valid ? rsp_head.rdata : 32'd0;
  assign rsp_err   = rsp_valid & rsp_head.err;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed bench for ahb_cmd_master: single writes/reads, pipelining, wait
// states, lane handling, misalignment, response back-pressure and reset.
module tb_ahb_cmd_master;
  import ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [2:0]  cmd_size = 3'd0;
  logic [31:0] cmd_addr = 32'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA = 32'd0;
  logic        HREADY = 1'b1;
`ifdef AHB_CMD_MASTER_HRESP_EN
  logic        HRESP = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  ahb_cmd_master dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HRDATA(HRDATA),
`ifdef AHB_CMD_MASTER_HRESP_EN
    .HRESP(HRESP),
`endif
    .HREADY(HREADY)
  );

  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_cmd(input logic w, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_size  = sz;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic send(input logic w, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] d);
    drive_cmd(w, sz, a, d);
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_htrans"}, 32'(HTRANS), 32'h0);
    check_eq({tag, "_haddr"}, HADDR, 32'h0);
    check_eq({tag, "_hsize"}, 32'(HSIZE), 32'h0);
    check_eq({tag, "_hwrite"}, 32'(HWRITE), 32'h0);
    check_eq({tag, "_hwdata"}, HWDATA, 32'h0);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check_eq({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    check_eq({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
    check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h0);
  endtask

  int idx;
  int issued;
  logic acc;

  initial begin
    // Reset state
    tick;
    tick;
    check_reset_values("rst");
    HRESET = 1'b0;
    tick;
    check_eq("ready_after_rst", 32'(cmd_ready), 32'h1);

    // Byte write 0x82 to 0x5300_0001
    send(1'b1, HSIZE_BYTE, 32'h5300_0001, 32'h0000_0082);
    check_eq("wb_htrans", 32'(HTRANS), 32'h2);
    check_eq("wb_haddr", HADDR, 32'h5300_0001);
    check_eq("wb_hsize", 32'(HSIZE), 32'h0);
    check_eq("wb_hwrite", 32'(HWRITE), 32'h1);
    tick;
    check_eq("wb_idle", 32'(HTRANS), 32'h0);
    check_eq("wb_hwdata", HWDATA, 32'h0000_8200);
    tick;
    check_eq("wb_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("wb_rsp_err", 32'(rsp_err), 32'h0);
    tick;
    check_eq("wb_rsp_gone", 32'(rsp_valid), 32'h0);

    // Four back-to-back word writes, zero-wait slave
    for (int k = 0; k < 4; k++) begin
      drive_cmd(1'b1, HSIZE_WORD, 32'h5300_0100 + 32'(4 * k), 32'hA5A5_0000 + 32'(k));
      tick;
      check_eq("b2b_htrans", 32'(HTRANS), 32'h2);
      check_eq("b2b_haddr", HADDR, 32'h5300_0100 + 32'(4 * k));
      if (k > 0) check_eq("b2b_hwdata", HWDATA, 32'hA5A5_0000 + 32'(k - 1));
      if (k > 1) check_eq("b2b_rsp_valid", 32'(rsp_valid), 32'h1);
    end
    cmd_valid = 1'b0;
    tick;
    check_eq("b2b_idle", 32'(HTRANS), 32'h0);
    check_eq("b2b_hwdata_last", HWDATA, 32'hA5A5_0003);
    check_eq("b2b_rsp3", 32'(rsp_valid), 32'h1);
    tick;
    check_eq("b2b_rsp4", 32'(rsp_valid), 32'h1);
    check_eq("b2b_rsp4_err", 32'(rsp_err), 32'h0);
    tick;
    check_eq("b2b_rsp_done", 32'(rsp_valid), 32'h0);

    // Word read with 2 wait states, byte read from lane 3 pipelined behind it
    send(1'b0, HSIZE_WORD, 32'h5300_0000, 32'h0);
    check_eq("rd_htrans", 32'(HTRANS), 32'h2);
    check_eq("rd_haddr", HADDR, 32'h5300_0000);
    drive_cmd(1'b0, HSIZE_BYTE, 32'h5300_0003, 32'h0);
    tick;
    cmd_valid = 1'b0;
    check_eq("rd2_htrans", 32'(HTRANS), 32'h2);
    check_eq("rd2_haddr", HADDR, 32'h5300_0003);
    HREADY = 1'b0;
    for (int w = 0; w < 2; w++) begin
      tick;
      check_eq("wait_htrans", 32'(HTRANS), 32'h2);
      check_eq("wait_haddr", HADDR, 32'h5300_0003);
      check_eq("wait_hsize", 32'(HSIZE), 32'h0);
      check_eq("wait_hwrite", 32'(HWRITE), 32'h0);
      check_eq("wait_rsp_valid", 32'(rsp_valid), 32'h0);
    end
    HREADY = 1'b1;
    HRDATA = 32'h0C11_8201;
    tick;
    check_eq("rdw_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("rdw_rdata", rsp_rdata, 32'h0C11_8201);
    check_eq("rdw_err", 32'(rsp_err), 32'h0);
    check_eq("rdw_idle", 32'(HTRANS), 32'h0);
    HRDATA = 32'h3649_AF13;
    tick;
    check_eq("rdb_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("rdb_rdata", rsp_rdata, 32'h0000_0036);
    tick;
    check_eq("rdb_rsp_done", 32'(rsp_valid), 32'h0);

    // Misaligned half-word: no bus transfer, error response
    send(1'b0, HSIZE_HALF, 32'h5300_0001, 32'h0);
    check_eq("mis_no_nonseq", 32'(HTRANS), 32'h0);
    tick;
    check_eq("mis_no_nonseq2", 32'(HTRANS), 32'h0);
    check_eq("mis_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("mis_rsp_err", 32'(rsp_err), 32'h1);
    check_eq("mis_rsp_rdata", rsp_rdata, 32'h0);
    tick;
    check_eq("mis_rsp_done", 32'(rsp_valid), 32'h0);

    // Response back-pressure with six commands offered
    rsp_ready = 1'b0;
    idx = 0;
    issued = 0;
    for (int c = 0; c < 16; c++) begin
      if (idx < 6) drive_cmd(1'b1, HSIZE_BYTE, 32'h5300_0010 + 32'(idx), 32'(idx));
      else cmd_valid = 1'b0;
      acc = cmd_valid & cmd_ready;
      tick;
      if (acc) idx++;
      if (HTRANS == 2'b10) issued++;
    end
    cmd_valid = 1'b0;
    check_eq("bp_issued", 32'(issued), 32'd2);
    check_eq("bp_accepted", 32'(idx), 32'd6);
    check_eq("bp_idle", 32'(HTRANS), 32'h0);
    check_eq("bp_cmd_full", 32'(cmd_ready), 32'h0);
    check_eq("bp_rsp_valid", 32'(rsp_valid), 32'h1);

    // Free one slot, start a transfer, then reset in the middle of it
    rsp_ready = 1'b1;
    tick;
    check_eq("mid_nonseq", 32'(HTRANS), 32'h2);
    rsp_ready = 1'b0;
    tick;
    check_eq("mid_idle", 32'(HTRANS), 32'h0);
    HREADY = 1'b0;
    #2;
    HRESET = 1'b1;
    #1;
    check_reset_values("midrst");
    tick;
    HRESET = 1'b0;
    HREADY = 1'b1;
    rsp_ready = 1'b1;
    tick;
    check_eq("post_rst_ready", 32'(cmd_ready), 32'h1);
    check_eq("post_rst_rsp", 32'(rsp_valid), 32'h0);
    check_eq("post_rst_idle", 32'(HTRANS), 32'h0);
    tick;
    check_eq("post_rst_rsp2", 32'(rsp_valid), 32'h0);

`ifdef AHB_CMD_MASTER_HRESP_EN
    // ERROR on a write with a read pipelined behind it
    send(1'b1, HSIZE_WORD, 32'h5300_0020, 32'hDEAD_BEEF);
    drive_cmd(1'b0, HSIZE_WORD, 32'h5300_0024, 32'h0);
    tick;
    cmd_valid = 1'b0;
    check_eq("er_pipe_nonseq", 32'(HTRANS), 32'h2);
    check_eq("er_pipe_haddr", HADDR, 32'h5300_0024);
    HREADY = 1'b0;
    HRESP = 1'b1;
    tick;
    check_eq("er_cycle2_idle", 32'(HTRANS), 32'h0);
    HREADY = 1'b1;
    tick;
    check_eq("er_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("er_rsp_err", 32'(rsp_err), 32'h1);
    check_eq("er_reissue", 32'(HTRANS), 32'h2);
    check_eq("er_reissue_addr", HADDR, 32'h5300_0024);
    HRESP = 1'b0;
    HRDATA = 32'h1234_5678;
    tick;
    check_eq("er_rd_dphase", 32'(rsp_valid), 32'h0);
    tick;
    check_eq("er_rd_rsp", 32'(rsp_valid), 32'h1);
    check_eq("er_rd_rdata", rsp_rdata, 32'h1234_5678);
    check_eq("er_rd_err", 32'(rsp_err), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
